// File: rtl/dma_seg_ram_rd_responder_pkg.sv
// Shared helpers for the segmented DMA RAM read responder.
// Width derivations used by every segment instance.
package dma_seg_ram_rd_responder_pkg;

  localparam int DEF_PIPELINE = 2;

  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dma_seg_ram_rd_responder_if.sv
// Write/read command and response bundle of the segmented DMA RAM.
// Segment n owns slice n of every bus.
interface dma_seg_ram_rd_responder_if #(
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 64,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
  parameter int SEG_ADDR_WIDTH = 8
);

  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   wr_cmd_be;
  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] wr_cmd_addr;
  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] wr_cmd_data;
  logic [SEG_COUNT-1:0]                wr_cmd_valid;
  logic [SEG_COUNT-1:0]                wr_cmd_ready;
  logic [SEG_COUNT-1:0]                wr_done;
  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] rd_cmd_addr;
  logic [SEG_COUNT-1:0]                rd_cmd_valid;
  logic [SEG_COUNT-1:0]                rd_cmd_ready;
  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] rd_resp_data;
  logic [SEG_COUNT-1:0]                rd_resp_valid;
  logic [SEG_COUNT-1:0]                rd_resp_ready;

  modport master (
    output wr_cmd_be, wr_cmd_addr, wr_cmd_data, wr_cmd_valid,
    output rd_cmd_addr, rd_cmd_valid, rd_resp_ready,
    input  wr_cmd_ready, wr_done, rd_cmd_ready,
    input  rd_resp_data, rd_resp_valid
  );

  modport slave (
    input  wr_cmd_be, wr_cmd_addr, wr_cmd_data, wr_cmd_valid,
    input  rd_cmd_addr, rd_cmd_valid, rd_resp_ready,
    output wr_cmd_ready, wr_done, rd_cmd_ready,
    output rd_resp_data, rd_resp_valid
  );

endinterface

// File: rtl/dma_seg_ram_rd_responder_seg.sv
// One RAM segment: byte-write memory, fixed-latency read pipe,
// FWFT response FIFO and the credit counter that keeps it lossless.
module dma_seg_ram_rd_responder_seg
  import dma_seg_ram_rd_responder_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int BE_W       = DATA_W / 8,
  parameter int ADDR_W     = 8,
  parameter int PIPELINE   = 2,
  parameter int FIFO_DEPTH = PIPELINE + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BE_W-1:0]   wr_cmd_be,
  input  logic [ADDR_W-1:0] wr_cmd_addr,
  input  logic [DATA_W-1:0] wr_cmd_data,
  input  logic              wr_cmd_valid,
  output logic              wr_cmd_ready,
  output logic              wr_done,
  input  logic [ADDR_W-1:0] rd_cmd_addr,
  input  logic              rd_cmd_valid,
  output logic              rd_cmd_ready,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready
);

  localparam int FIFO_PTR_W = fifo_ptr_w(FIFO_DEPTH);
  localparam int CNT_W      = cnt_w(FIFO_DEPTH);
  localparam int IDX_W      = FIFO_PTR_W - 1;

  logic [DATA_W-1:0]     mem [2**ADDR_W];
  logic [DATA_W-1:0]     fifo [FIFO_DEPTH];
  logic [DATA_W-1:0]     rd_data;
  logic [DATA_W-1:0]     push_d;
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  wr_fire;
  logic                  wr_done_q;
  logic                  rd_fire;
  logic                  pop;
  logic                  push_v;

  function automatic logic [FIFO_PTR_W-1:0] ptr_next(
    input logic [FIFO_PTR_W-1:0] p
  );
    if (p[IDX_W-1:0] == IDX_W'(FIFO_DEPTH - 1))
      ptr_next = {~p[FIFO_PTR_W-1], {IDX_W{1'b0}}};
    else
      ptr_next = p + FIFO_PTR_W'(1);
  endfunction

  assign wr_cmd_ready = !rst;
  assign wr_fire      = wr_cmd_valid && wr_cmd_ready;
  assign wr_done      = wr_done_q && !rst;

  // RAM contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_cmd_be[b])
          mem[wr_cmd_addr][b*8 +: 8] <= wr_cmd_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wr_done_q <= 1'b0;
    else     wr_done_q <= wr_fire;
  end

  assign rd_cmd_ready = (cnt < CNT_W'(FIFO_DEPTH)) && !rst;
  assign rd_fire      = rd_cmd_valid && rd_cmd_ready;
  assign pop          = rd_resp_valid && rd_resp_ready;
  assign rd_data      = mem[rd_cmd_addr];

  if (PIPELINE == 1) begin : g_direct
    assign push_v = rd_fire;
    assign push_d = rd_data;
  end else begin : g_pipe
    logic [PIPELINE-2:0] sv;
    logic [DATA_W-1:0]   sd [PIPELINE-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        sv <= '0;
      end else begin
        sv[0] <= rd_fire;
        for (int k = 1; k < PIPELINE - 1; k++)
          sv[k] <= sv[k-1];
      end
    end

    always_ff @(posedge clk) begin
      sd[0] <= rd_data;
      for (int k = 1; k < PIPELINE - 1; k++)
        sd[k] <= sd[k-1];
    end

    assign push_v = sv[PIPELINE-2];
    assign push_d = sd[PIPELINE-2];
  end

  // credits guarantee a free slot whenever push_v is set
  always_ff @(posedge clk) begin
    if (push_v) fifo[wr_ptr[IDX_W-1:0]] <= push_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_v) wr_ptr <= ptr_next(wr_ptr);
      if (pop)    rd_ptr <= ptr_next(rd_ptr);
      if (rd_fire && !pop)
        cnt <= cnt + CNT_W'(1);
      else if (pop && !rd_fire)
        cnt <= cnt - CNT_W'(1);
    end
  end

  assign rd_resp_valid = (wr_ptr != rd_ptr) && !rst;
  assign rd_resp_data  = fifo[rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/dma_seg_ram_rd_responder.sv
// Segmented dual-port RAM answering DMA rd_cmd/rd_resp requests.
// Each segment is an independent instance on its own bus slice.
module dma_seg_ram_rd_responder
  import dma_seg_ram_rd_responder_pkg::*;
#(
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 64,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
  parameter int SEG_ADDR_WIDTH = 8,
  parameter int PIPELINE       = DEF_PIPELINE,
  parameter int FIFO_DEPTH     = PIPELINE + 2
) (
  input logic clk,
  input logic rst,
  dma_seg_ram_rd_responder_if.slave bus
);

  localparam int DW = SEG_DATA_WIDTH;
  localparam int BW = SEG_BE_WIDTH;
  localparam int AW = SEG_ADDR_WIDTH;

  logic [SEG_COUNT-1:0]    wr_cmd_ready;
  logic [SEG_COUNT-1:0]    wr_done;
  logic [SEG_COUNT-1:0]    rd_cmd_ready;
  logic [SEG_COUNT-1:0]    rd_resp_valid;
  logic [SEG_COUNT*DW-1:0] rd_resp_data;

  for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
    dma_seg_ram_rd_responder_seg #(
      .DATA_W     (DW),
      .BE_W       (BW),
      .ADDR_W     (AW),
      .PIPELINE   (PIPELINE),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_seg (
      .clk           (clk),
      .rst           (rst),
      .wr_cmd_be     (bus.wr_cmd_be[n*BW +: BW]),
      .wr_cmd_addr   (bus.wr_cmd_addr[n*AW +: AW]),
      .wr_cmd_data   (bus.wr_cmd_data[n*DW +: DW]),
      .wr_cmd_valid  (bus.wr_cmd_valid[n]),
      .wr_cmd_ready  (wr_cmd_ready[n]),
      .wr_done       (wr_done[n]),
      .rd_cmd_addr   (bus.rd_cmd_addr[n*AW +: AW]),
      .rd_cmd_valid  (bus.rd_cmd_valid[n]),
      .rd_cmd_ready  (rd_cmd_ready[n]),
      .rd_resp_data  (rd_resp_data[n*DW +: DW]),
      .rd_resp_valid (rd_resp_valid[n]),
      .rd_resp_ready (bus.rd_resp_ready[n])
    );
  end

  assign bus.wr_cmd_ready  = wr_cmd_ready;
  assign bus.wr_done       = wr_done;
  assign bus.rd_cmd_ready  = rd_cmd_ready;
  assign bus.rd_resp_valid = rd_resp_valid;
  assign bus.rd_resp_data  = rd_resp_data;

endmodule

// File: tb/tb_dma_seg_ram_rd_responder.sv
// Bench for dma_seg_ram_rd_responder: vector table, scoreboard,
// and directed backpressure / collision / reset sequences.
module tb_dma_seg_ram_rd_responder;

  localparam int SC = 2;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int AW = 8;
  localparam int P  = 2;
  localparam int FD = P + 2;

  typedef struct {
    int          seg;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [DW-1:0] model [SC][2**AW];
  logic [DW-1:0] sbq [SC][$];
  int            resp_cnt [SC] = '{default: 0};
  int            done_cnt [SC] = '{default: 0};

  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  logic [BW-1:0] m_be;

  dma_seg_ram_rd_responder_if #(
    .SEG_COUNT(SC), .SEG_DATA_WIDTH(DW),
    .SEG_BE_WIDTH(BW), .SEG_ADDR_WIDTH(AW)
  ) bus ();

  dma_seg_ram_rd_responder #(
    .SEG_COUNT(SC), .SEG_DATA_WIDTH(DW),
    .SEG_BE_WIDTH(BW), .SEG_ADDR_WIDTH(AW),
    .PIPELINE(P), .FIFO_DEPTH(FD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard and reference memory; reads see pre-write data
  always @(negedge clk) begin
    for (int s = 0; s < SC; s++) begin
      if (rst) begin
        sbq[s].delete();
      end else begin
        if (bus.wr_done[s]) done_cnt[s]++;
        if (bus.rd_resp_valid[s] && bus.rd_resp_ready[s]) begin
          resp_cnt[s]++;
          m_d = bus.rd_resp_data[s*DW +: DW];
          if (sbq[s].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected seg%0d: got %h expected none",
                     s, m_d);
          end else begin
            check($sformatf("sb_resp_seg%0d", s), m_d,
                  sbq[s].pop_front());
          end
        end
        if (bus.rd_cmd_valid[s] && bus.rd_cmd_ready[s]) begin
          m_a = bus.rd_cmd_addr[s*AW +: AW];
          sbq[s].push_back(model[s][m_a]);
        end
        if (bus.wr_cmd_valid[s] && bus.wr_cmd_ready[s]) begin
          m_a  = bus.wr_cmd_addr[s*AW +: AW];
          m_d  = bus.wr_cmd_data[s*DW +: DW];
          m_be = bus.wr_cmd_be[s*BW +: BW];
          for (int b = 0; b < BW; b++)
            if (m_be[b]) model[s][m_a][b*8 +: 8] = m_d[b*8 +: 8];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(int s, int a, logic [63:0] d,
                        logic [7:0] be, logic v);
    bus.wr_cmd_addr[s*AW +: AW] = AW'(a);
    bus.wr_cmd_data[s*DW +: DW] = d;
    bus.wr_cmd_be[s*BW +: BW]   = be;
    bus.wr_cmd_valid[s]         = v;
  endtask

  task automatic set_rd(int s, int a, logic v);
    bus.rd_cmd_addr[s*AW +: AW] = AW'(a);
    bus.rd_cmd_valid[s]         = v;
  endtask

  task automatic do_write(int s, int a, logic [63:0] d,
                          logic [7:0] be);
    set_wr(s, a, d, be, 1'b1);
    @(negedge clk);
    check("wr_cmd_ready", bus.wr_cmd_ready[s], 1);
    tick();
    set_wr(s, a, d, be, 1'b0);
    @(negedge clk);
    check("wr_done_pulse", bus.wr_done[s], 1);
    tick();
    @(negedge clk);
    check("wr_done_single", bus.wr_done[s], 0);
    tick();
  endtask

  task automatic get_resp(int s, output logic [63:0] d,
                          output int lat, output logic ok);
    ok  = 1'b0;
    lat = 0;
    d   = '0;
    while (!ok && lat < 50) begin
      @(negedge clk);
      if (bus.rd_resp_valid[s]) begin
        ok = 1'b1;
        d  = bus.rd_resp_data[s*DW +: DW];
      end
      tick();
      if (!ok) lat++;
    end
  endtask

  task automatic do_read(int s, int a, logic [63:0] exp);
    logic [63:0] d;
    int          lat;
    logic        ok;
    bus.rd_resp_ready[s] = 1'b1;
    set_rd(s, a, 1'b1);
    @(negedge clk);
    check("rd_cmd_ready", bus.rd_cmd_ready[s], 1);
    tick();
    set_rd(s, a, 1'b0);
    get_resp(s, d, lat, ok);
    check("rd_resp_seen", ok, 1);
    check("rd_latency", 64'(lat + 1), 64'(P));
    check("rd_data", d, exp);
  endtask

  function automatic logic [63:0] pat(int s, int a);
    return {32'hC0DE_0000 | 32'(s), 32'h5A5A_0000 ^ 32'(a)};
  endfunction

  vec_t tv [6];

  initial begin
    logic [63:0] d1, d2;
    int          lat, nxt, base, vcnt;
    logic        ok;

    tv[0] = '{0, 8'h05, 64'h1122334455667788, 8'hFF,
              64'h1122334455667788};
    tv[1] = '{0, 8'h10, 64'hFFFFFFFFFFFFFFFF, 8'hFF,
              64'hFFFFFFFFFFFFFFFF};
    tv[2] = '{0, 8'h10, 64'h0, 8'h0F, 64'hFFFFFFFF00000000};
    tv[3] = '{0, 8'h10, 64'h0, 8'h00, 64'hFFFFFFFF00000000};
    tv[4] = '{0, 8'h10, 64'h0123456789ABCDEF, 8'h81,
              64'h01FFFFFF000000EF};
    tv[5] = '{1, 8'hFF, 64'hA5A5A5A5A5A5A5A5, 8'hFF,
              64'hA5A5A5A5A5A5A5A5};

    bus.wr_cmd_be     = '0;
    bus.wr_cmd_addr   = '0;
    bus.wr_cmd_data   = '0;
    bus.wr_cmd_valid  = '0;
    bus.rd_cmd_addr   = '0;
    bus.rd_cmd_valid  = '0;
    bus.rd_resp_ready = '1;

    repeat (3) tick();
    @(negedge clk);
    check("rst_rd_cmd_ready", bus.rd_cmd_ready, 0);
    check("rst_wr_cmd_ready", bus.wr_cmd_ready, 0);
    check("rst_rd_resp_valid", bus.rd_resp_valid, 0);
    check("rst_wr_done", bus.wr_done, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rd_ready", bus.rd_cmd_ready, 2'b11);
    check("post_rst_wr_ready", bus.wr_cmd_ready, 2'b11);
    check("post_rst_valid", bus.rd_resp_valid, 0);
    tick();

    // back-to-back writes to both segments
    for (int a = 0; a < 32; a++) begin
      set_wr(0, a, pat(0, a), 8'hFF, 1'b1);
      set_wr(1, a, pat(1, a), 8'hFF, 1'b1);
      tick();
    end
    set_wr(0, 0, '0, '0, 1'b0);
    set_wr(1, 0, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    check("prefill_done_seg0", 64'(done_cnt[0]), 64'd32);
    check("prefill_done_seg1", 64'(done_cnt[1]), 64'd32);
    tick();

    for (int i = 0; i < 6; i++) begin
      do_write(tv[i].seg, tv[i].addr, tv[i].wdata, tv[i].be);
      do_read(tv[i].seg, tv[i].addr, tv[i].exp);
    end

    // backpressure: only FD reads fit while resp is stalled
    bus.rd_resp_ready[0] = 1'b0;
    base = resp_cnt[0];
    nxt  = 0;
    for (int c = 0; c < 8; c++) begin
      set_rd(0, nxt, 1'b1);
      @(negedge clk);
      if (bus.rd_cmd_ready[0]) nxt++;
      tick();
    end
    check("bp_accepted", 64'(nxt), 64'(FD));
    @(negedge clk);
    check("bp_ready_low", bus.rd_cmd_ready[0], 0);
    check("bp_valid_held", bus.rd_resp_valid[0], 1);
    tick();
    bus.rd_resp_ready[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_rd(0, nxt, nxt < 10);
      @(negedge clk);
      check($sformatf("bp_stream_%0d", i), bus.rd_resp_valid[0], 1);
      if (bus.rd_cmd_ready[0] && nxt < 10) nxt++;
      tick();
    end
    set_rd(0, 0, 1'b0);
    check("bp_all_issued", 64'(nxt), 64'd10);
    @(negedge clk);
    #1;
    check("bp_resp_count", 64'(resp_cnt[0] - base), 64'd10);
    check("bp_sb_empty", 64'(sbq[0].size()), 64'd0);
    tick();

    // read/write collision and write behind an in-flight read
    do_write(0, 8'h20, 64'hAAAA00001111AAAA, 8'hFF);
    do_write(0, 8'h21, 64'hCCCC00003333CCCC, 8'hFF);
    set_wr(0, 8'h20, 64'hBBBB00002222BBBB, 8'hFF, 1'b1);
    set_rd(0, 8'h20, 1'b1);
    @(negedge clk);
    check("col_rd_ready", bus.rd_cmd_ready[0], 1);
    tick();
    set_wr(0, 0, '0, '0, 1'b0);
    tick();
    set_rd(0, 0, 1'b0);
    get_resp(0, d1, lat, ok);
    check("col_first_seen", ok, 1);
    get_resp(0, d2, lat, ok);
    check("col_second_seen", ok, 1);
    check("col_old_data", d1, 64'hAAAA00001111AAAA);
    check("col_new_data", d2, 64'hBBBB00002222BBBB);
    set_rd(0, 8'h21, 1'b1);
    tick();
    set_rd(0, 0, 1'b0);
    set_wr(0, 8'h21, 64'hDDDD00004444DDDD, 8'hFF, 1'b1);
    tick();
    set_wr(0, 0, '0, '0, 1'b0);
    get_resp(0, d1, lat, ok);
    check("inflight_seen", ok, 1);
    check("inflight_old_data", d1, 64'hCCCC00003333CCCC);
    tick();
    do_read(0, 8'h21, 64'hDDDD00004444DDDD);

    // segment independence: seg0 full, seg1 streaming
    bus.rd_resp_ready[0] = 1'b0;
    bus.rd_resp_ready[1] = 1'b1;
    base = resp_cnt[1];
    nxt  = 0;
    for (int c = 0; c < 16; c++) begin
      set_rd(0, 0, 1'b1);
      set_rd(1, nxt, 1'b1);
      @(negedge clk);
      if (bus.rd_cmd_ready[1]) nxt++;
      tick();
    end
    set_rd(1, 0, 1'b0);
    check("ind_seg1_accepts", 64'(nxt), 64'd16);
    repeat (P) @(negedge clk);
    #1;
    check("ind_seg1_resps", 64'(resp_cnt[1] - base), 64'd16);
    check("ind_seg1_sb_empty", 64'(sbq[1].size()), 64'd0);
    check("ind_seg0_held", 64'(sbq[0].size()), 64'(FD));
    check("ind_seg0_valid", bus.rd_resp_valid[0], 1);
    check("ind_seg0_ready", bus.rd_cmd_ready[0], 0);
    tick();
    set_rd(0, 0, 1'b0);
    bus.rd_resp_ready[0] = 1'b1;
    repeat (8) tick();
    check("ind_seg0_drained", 64'(sbq[0].size()), 64'd0);

    // reset with reads in flight
    bus.rd_resp_ready[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_rd(0, c, 1'b1);
      tick();
    end
    set_rd(0, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", bus.rd_resp_valid[0], 0);
    check("mid_rst_rd_ready", bus.rd_cmd_ready[0], 0);
    check("mid_rst_wr_ready", bus.wr_cmd_ready[0], 0);
    tick();
    rst = 1'b0;
    bus.rd_resp_ready[0] = 1'b1;
    @(negedge clk);
    check("after_rst_rd_ready", bus.rd_cmd_ready[0], 1);
    check("after_rst_wr_ready", bus.wr_cmd_ready[0], 1);
    vcnt = 0;
    tick();
    repeat (6) begin
      @(negedge clk);
      if (bus.rd_resp_valid[0]) vcnt++;
      tick();
    end
    check("after_rst_no_resp", 64'(vcnt), 64'd0);
    do_read(0, 8'h05, 64'h1122334455667788);
    do_read(1, 8'hFF, 64'hA5A5A5A5A5A5A5A5);

    repeat (4) tick();
    check("end_sb0_empty", 64'(sbq[0].size()), 64'd0);
    check("end_sb1_empty", 64'(sbq[1].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
